// File: rtl/remap_table_ctrl.sv
// Command sequencer for the 128x7 channel remap regfile: single write, clear, rotated-identity fill, check.
// Optional feature macro: REMAP_CHECK_EN (compare/mismatch logic for CHECK; without it CHECK just reports err).
module remap_table_ctrl #(
    parameter int DEPTH = 128,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [6:0]       cmd_addr,
    input  logic [6:0]       cmd_data,
    output logic             rf_we,
    output logic             rf_reset,
    output logic [6:0]       rf_wr_addr,
    output logic [6:0]       rf_data,
    input  logic [6:0]       rf_rd_debug,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [6:0]       err_addr,
    output logic [CNT_W-1:0] err_cnt
);

    typedef enum logic [2:0] {
        S_IDLE, S_WRITE, S_CLEAR, S_FILL, S_CHECK, S_DONE
    } state_t;

    typedef struct packed {
        logic [6:0] addr;
        logic [6:0] data;
    } cmd_t;

    localparam logic [1:0] OP_WRITE = 2'b00;
    localparam logic [1:0] OP_CLEAR = 2'b01;
    localparam logic [1:0] OP_FILL  = 2'b10;
    localparam logic [1:0] OP_CHECK = 2'b11;
    localparam logic [6:0] LAST_IDX = 7'(DEPTH - 1);
    localparam logic [7:0] DEPTH_8  = 8'(DEPTH);

    state_t state, state_nxt;
    cmd_t   cmd_q;
    logic   accept;
    logic   last_idx;
    logic   addr_ok;
    logic   addr_ok_q;

    // rf_wr_addr doubles as the sweep index for FILL/CHECK
    assign accept    = cmd_valid && cmd_ready;
    assign last_idx  = (rf_wr_addr == LAST_IDX);
    assign addr_ok   = ({1'b0, cmd_addr} < DEPTH_8);
    assign addr_ok_q = ({1'b0, cmd_q.addr} < DEPTH_8);

    assign cmd_ready = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cmd_q <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cmd_q.addr <= cmd_addr;
                cmd_q.data <= cmd_data;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    case (cmd_op)
                        OP_WRITE: state_nxt = S_WRITE;
                        OP_CLEAR: state_nxt = S_CLEAR;
                        OP_FILL:  state_nxt = S_FILL;
                        default:  state_nxt = S_CHECK;
                    endcase
                end
            end
            S_WRITE, S_CLEAR: state_nxt = S_DONE;
            S_FILL:           if (last_idx) state_nxt = S_DONE;
`ifdef REMAP_CHECK_EN
            S_CHECK:          if (last_idx) state_nxt = S_DONE;
`else
            S_CHECK:          state_nxt = S_DONE;
`endif
            S_DONE:           state_nxt = S_IDLE;
            default:          state_nxt = S_IDLE;
        endcase
    end

    // Write-port strobes are launched one edge ahead so they are registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            rf_we      <= 1'b0;
            rf_reset   <= 1'b0;
            rf_wr_addr <= '0;
            rf_data    <= '0;
        end else begin
            rf_we    <= 1'b0;
            rf_reset <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_WRITE: begin
                                rf_we      <= addr_ok;
                                rf_wr_addr <= cmd_addr;
                                rf_data    <= cmd_data;
                            end
                            OP_CLEAR: rf_reset <= 1'b1;
                            OP_FILL: begin
                                rf_we      <= 1'b1;
                                rf_wr_addr <= '0;
                                rf_data    <= cmd_data;
                            end
                            default: rf_wr_addr <= '0;
                        endcase
                    end
                end
                S_FILL: begin
                    if (!last_idx) begin
                        rf_we      <= 1'b1;
                        rf_wr_addr <= rf_wr_addr + 7'd1;
                        rf_data    <= rf_data + 7'd1;
                    end
                end
`ifdef REMAP_CHECK_EN
                S_CHECK: begin
                    if (!last_idx) rf_wr_addr <= rf_wr_addr + 7'd1;
                end
`endif
                default: ;
            endcase
        end
    end

`ifdef REMAP_CHECK_EN
    logic [6:0] exp_val;
    logic       mismatch;

    assign exp_val  = rf_wr_addr + cmd_q.data;
    assign mismatch = (state == S_CHECK) && (rf_rd_debug != exp_val);

    always_ff @(posedge clk) begin
        if (reset) begin
            err      <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else if (accept) begin
            err      <= 1'b0;
            err_addr <= '0;
            err_cnt  <= '0;
        end else begin
            if (state == S_WRITE) err <= !addr_ok_q;
            if (mismatch) begin
                err <= 1'b1;
                if (!err) err_addr <= rf_wr_addr;
                if (err_cnt != {CNT_W{1'b1}}) err_cnt <= err_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_chk;

    assign unused_chk = ^{rf_rd_debug, cmd_q.data};
    assign err_addr   = '0;
    assign err_cnt    = '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= 1'b0;
        end else begin
            if (state == S_WRITE) err <= !addr_ok_q;
            if (state == S_CHECK) err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_remap_table_ctrl.sv
// Randomized self-checking bench: two controllers (DEPTH 128 and 64) each driving a behavioural regfile,
// checked against a table-level reference model of the command semantics.
module tb_remap_table_ctrl;

    localparam int CNT_MAX = 255;
    localparam logic [1:0] OP_WRITE = 2'b00, OP_CLEAR = 2'b01, OP_FILL = 2'b10, OP_CHECK = 2'b11;

    logic clk = 1'b0;
    logic reset;
    logic [1:0] cmd_op;
    logic [6:0] cmd_addr, cmd_data;
    logic [1:0] vld;
    logic [1:0] rdy, we, rrst, bsy, dn, er;
    logic [1:0][6:0] waddr, wdata, dbg, eaddr;
    logic [1:0][7:0] ecnt;

    logic [6:0] mem [2][128];
    int ref_tbl [2][128];
    int n_chk = 0, n_err = 0;
    int o_err, o_eaddr, o_ecnt;

    always #5 clk = ~clk;

    remap_table_ctrl #(.DEPTH(128), .CNT_W(8)) u_dut0 (
        .clk(clk), .reset(reset), .cmd_valid(vld[0]), .cmd_ready(rdy[0]),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rf_we(we[0]), .rf_reset(rrst[0]), .rf_wr_addr(waddr[0]), .rf_data(wdata[0]),
        .rf_rd_debug(dbg[0]), .busy(bsy[0]), .done(dn[0]), .err(er[0]),
        .err_addr(eaddr[0]), .err_cnt(ecnt[0]));

    remap_table_ctrl #(.DEPTH(64), .CNT_W(8)) u_dut1 (
        .clk(clk), .reset(reset), .cmd_valid(vld[1]), .cmd_ready(rdy[1]),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
        .rf_we(we[1]), .rf_reset(rrst[1]), .rf_wr_addr(waddr[1]), .rf_data(wdata[1]),
        .rf_rd_debug(dbg[1]), .busy(bsy[1]), .done(dn[1]), .err(er[1]),
        .err_addr(eaddr[1]), .err_cnt(ecnt[1]));

    // behavioural regfiles with combinational debug read
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (rrst[s]) begin
                for (int i = 0; i < 128; i++) mem[s][i] <= 7'd0;
            end else if (we[s]) begin
                mem[s][waddr[s]] <= wdata[s];
            end
        end
    end
    assign dbg[0] = mem[0][waddr[0]];
    assign dbg[1] = mem[1][waddr[1]];

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    function automatic int depth_of(input int s);
        return (s == 0) ? 128 : 64;
    endfunction

    task automatic chk_reset_vals(input int s, input string tag);
        chk({tag, "_ready"}, rdy[s], 1);
        chk({tag, "_busy"}, bsy[s], 0);
        chk({tag, "_done"}, dn[s], 0);
        chk({tag, "_err"}, er[s], 0);
        chk({tag, "_we_rst"}, {we[s], rrst[s]}, 0);
        chk({tag, "_addr_data"}, {waddr[s], wdata[s]}, 0);
        chk({tag, "_eaddr_ecnt"}, {eaddr[s], ecnt[s]}, 0);
    endtask

    task automatic do_cmd(input int s, input logic [1:0] op, input int a, input int d,
                          input bit hold, input string tag);
        int lat, nwr, nrst, bad, D, exp_lat, exp_nwr, exp_rst, exp_err, exp_cnt, exp_addr, diff;
        D = depth_of(s);
        @(negedge clk);
        cmd_op = op; cmd_addr = 7'(a); cmd_data = 7'(d);
        chk({tag, "_ready"}, rdy[s], 1);
        vld[s] = 1'b1;
        @(posedge clk);
        lat = 0; nwr = 0; nrst = 0; bad = 0;
        for (int k = 1; k <= 400; k++) begin
            @(negedge clk);
            if (!hold) vld[s] = 1'b0;
            if (we[s]) begin
                if (op == OP_FILL) begin
                    if (waddr[s] != 7'(nwr) || wdata[s] != 7'((nwr + d) % 128)) bad++;
                end else if (waddr[s] != 7'(a) || wdata[s] != 7'(d)) bad++;
                nwr++;
            end
            if (rrst[s]) nrst++;
            if (we[s] && rrst[s]) bad++;
            if (rdy[s] || !bsy[s]) bad++;
            if (dn[s]) begin
                lat = k;
                break;
            end
        end
        vld[s] = 1'b0;
        if (lat == 0) chk({tag, "_timeout"}, 0, 1);
        o_err = er[s]; o_eaddr = eaddr[s]; o_ecnt = ecnt[s];

        exp_rst = 0; exp_nwr = 0; exp_err = 0; exp_cnt = 0; exp_addr = 0; exp_lat = 2;
        case (op)
            OP_WRITE: begin
                if (a < D) begin
                    exp_nwr = 1;
                    ref_tbl[s][a] = d;
                end else exp_err = 1;
            end
            OP_CLEAR: begin
                exp_rst = 1;
                for (int i = 0; i < 128; i++) ref_tbl[s][i] = 0;
            end
            OP_FILL: begin
                exp_lat = D + 1;
                exp_nwr = D;
                for (int i = 0; i < D; i++) ref_tbl[s][i] = (i + d) % 128;
            end
            default: begin
`ifdef REMAP_CHECK_EN
                exp_lat = D + 1;
                for (int i = D - 1; i >= 0; i--) begin
                    if (ref_tbl[s][i] != (i + d) % 128) begin
                        exp_cnt++;
                        exp_addr = i;
                    end
                end
                exp_err = (exp_cnt > 0);
                if (exp_cnt > CNT_MAX) exp_cnt = CNT_MAX;
`else
                exp_err = 1;
`endif
            end
        endcase
        chk({tag, "_latency"}, lat, exp_lat);
        chk({tag, "_nwrites"}, nwr, exp_nwr);
        chk({tag, "_nresets"}, nrst, exp_rst);
        chk({tag, "_protocol"}, bad, 0);
        chk({tag, "_err"}, o_err, exp_err);
        chk({tag, "_err_addr"}, o_eaddr, exp_addr);
        chk({tag, "_err_cnt"}, o_ecnt, exp_cnt);
        @(negedge clk);
        diff = 0;
        for (int i = 0; i < 128; i++) if (int'(mem[s][i]) != ref_tbl[s][i]) diff++;
        chk({tag, "_table"}, diff, 0);
        chk({tag, "_idle"}, {rdy[s], bsy[s], dn[s]}, 3'b100);
    endtask

    initial begin
        int bad;
        int last_r [2];
        reset = 1'b1; vld = 2'b00; cmd_op = 2'b00; cmd_addr = 7'd0; cmd_data = 7'd0;
        for (int s = 0; s < 2; s++) for (int i = 0; i < 128; i++) ref_tbl[s][i] = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals(0, "rst0");
        chk_reset_vals(1, "rst1");
        reset = 1'b0;

        // bring both regfiles to a known state
        do_cmd(0, OP_CLEAR, 0, 0, 0, "clr0");
        do_cmd(1, OP_CLEAR, 0, 0, 0, "clr1");

        do_cmd(0, OP_WRITE, 5, 7'h2A, 0, "wr5");
        chk("wr5_entry", mem[0][5], 7'h2A);

        do_cmd(0, OP_FILL, 0, 3, 0, "fill3");
        chk("fill3_e0", mem[0][0], 3);
        chk("fill3_e124", mem[0][124], 127);
        chk("fill3_e125", mem[0][125], 0);
        chk("fill3_e127", mem[0][127], 2);

        do_cmd(0, OP_FILL, 0, 0, 0, "fill0");
        do_cmd(0, OP_CHECK, 0, 0, 0, "chk_ok");
        do_cmd(0, OP_WRITE, 10, 7'h55, 0, "wr10");
        do_cmd(0, OP_CHECK, 0, 0, 0, "chk_bad");
`ifdef REMAP_CHECK_EN
        chk("chk_bad_spec", {o_err, o_eaddr, o_ecnt}, {32'd1, 32'd10, 32'd1});
`endif
        do_cmd(0, OP_CLEAR, 0, 0, 0, "clr_after");
        do_cmd(0, OP_CHECK, 0, 0, 0, "chk_clr");
`ifdef REMAP_CHECK_EN
        chk("chk_clr_spec", {o_eaddr, o_ecnt}, {32'd1, 32'd127});
`endif

        do_cmd(0, OP_FILL, 0, 9, 1, "fill_hold");
        do_cmd(1, OP_WRITE, 127, 7'h11, 0, "wr_oob");
        chk("wr_oob_err", o_err, 1);
        do_cmd(1, OP_WRITE, 63, 7'h22, 0, "wr_edge");
        do_cmd(1, OP_FILL, 0, 100, 0, "fill64");
        do_cmd(1, OP_CHECK, 0, 100, 0, "chk64");

        last_r[0] = 9; last_r[1] = 100;
        for (int n = 0; n < 24; n++) begin
            int s, op, a, d;
            s  = $urandom_range(0, 1);
            op = $urandom_range(0, 3);
            a  = $urandom_range(0, 127);
            d  = $urandom_range(0, 127);
            if (op == 3 && $urandom_range(0, 1) == 1) d = last_r[s];
            if (op == 2) last_r[s] = d;
            do_cmd(s, 2'(op), a, d, 0, $sformatf("rnd%0d", n));
        end

        // reset in cycle 40 of a FILL
        @(negedge clk);
        cmd_op = OP_FILL; cmd_data = 7'd5; vld[0] = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            vld[0] = 1'b0;
        end
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals(0, "rst_fill");
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 39; i++) if (int'(mem[0][i]) != (i + 5) % 128) bad++;
        chk("rst_fill_kept", bad, 0);
        for (int i = 0; i < 40; i++) ref_tbl[0][i] = (i + 5) % 128;
        do_cmd(0, OP_CHECK, 0, 5, 0, "chk_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
